bitonic_sort_scheduler: RTL and testbench
=========================================

Name: bitonic_sort_scheduler

Overview:
- Shares one pipelined bitonic sorter between NREQ requesters.
- Round-robin arbitration selects at most one request vector per cycle and issues it to the sorter. An in-order tag FIFO tracks which requester owns each in-flight vector.
- Results land in a response FIFO with valid/ready backpressure. The sorter cannot stall, so issue is credit-limited against response storage.
- Sits between client ports and the sorter top level; the sorter latency is opaque to this block.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DEPTH, 8, elements per vector; passed through to the sorter.
- WIDTH, 32, bits per element.
- RESP_DEPTH, 4, response FIFO entries; also the maximum in-flight plus buffered vectors (power of 2, >=2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  [NREQ]  requester r has a vector.
- req_ready  out  [NREQ]  grant to requester r; a handshake occurs when valid&ready.
- req_data  in  [NREQ][DEPTH][WIDTH]  unpacked request vectors.
- sort_valid_in  out  1  to sorter valid_in.
- sort_seq_in  out  [DEPTH][WIDTH]  to sorter seq_in.
- sort_valid_out  in  1  from sorter valid_out.
- sort_seq_out  in  [DEPTH][WIDTH]  from sorter seq_out.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  IDW = max(1, clog2(NREQ))  originating requester.
- resp_data  out  [DEPTH][WIDTH]  sorted vector.
- err_orphan  out  1  sticky: the sorter produced a result with no outstanding tag.

Behaviour:
- Reset (rst=0, asynchronous): all of the following clear.
  - sort_valid_in=0, sort_seq_in all 0.
  - resp_valid=0, resp_id=0, resp_data all 0.
  - err_orphan=0; RR pointer=0; both FIFOs empty; all counters 0.
  - req_ready is 0 while rst=0.
  - The sorter shares rst. Reset mid-operation drops all in-flight work and nothing is replayed.
- Credit:
  - total = tag_count + resp_count, using registered values.
  - Issue is allowed iff total < RESP_DEPTH.
  - A same-cycle resp pop or sorter output does not add credit until the next cycle.
- Arbitration (combinational from registered state):
  - If credit is available, grant the first r with req_valid[r]=1, searching ptr, ptr+1, ... mod NREQ.
  - Exactly that req_ready bit is high; all other bits are 0. All bits are 0 when there is no credit.
  - req_ready may depend on req_valid; req_valid must not depend on req_ready.
- Issue:
  - On a handshake for requester g, at the next edge: sort_valid_in<=1, sort_seq_in<=req_data[g], push g to the tag FIFO, ptr<=(g+1) mod NREQ.
  - Without a handshake: sort_valid_in<=0, and sort_seq_in is held.
  - Issue rate: at most 1 per cycle. Handshake-to-sort_valid_in latency is 1 cycle.
- Completion: on sort_valid_out=1 with tag FIFO non-empty, pop the tag head and push {tag, sort_seq_out} into the response FIFO in the same edge.
- Orphan result: sort_valid_out=1 with tag FIFO empty. Set err_orphan=1 (sticky until reset), discard the data, leave counters unchanged.
- Response FIFO:
  - Registered storage with first-word-fall-through head.
  - resp_valid = resp_count != 0; resp_id and resp_data show the head entry.
  - Pop when resp_valid & resp_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Pointers wrap modulo RESP_DEPTH.
  - Overflow cannot occur by construction of the credit rule. Assert resp_count <= RESP_DEPTH and tag_count <= RESP_DEPTH.
- Ordering: responses are delivered in issue order, since the sorter is in-order with fixed latency. There is no per-requester reordering.
- Simultaneous events:
  - Issue, completion and resp pop can all occur in one cycle; each counter updates independently by +1/-1/0.
  - tag_count: +issue, -completion.
  - resp_count: +completion, -pop.
- Hold rule: while resp_valid=1 and resp_ready=0, resp_id and resp_data stay stable.

Test Plan:
- Defaults; stub sorter with fixed 6-cycle latency that ascending-sorts. Requester 2 sends {7,3,5,1,8,2,6,4}. Required:
  - req_ready[2]=1 in the same cycle.
  - sort_valid_in=1 at the next edge.
  - Exactly one resp_valid beat with resp_id=2 and resp_data={1,2,3,4,5,6,7,8}.
- All 4 requesters hold req_valid=1 continuously, resp_ready=1. Required:
  - Grant order 0,1,2,3,0,1,...
  - No requester waits more than 4 grants.
  - resp_id sequence matches the grant order.
- resp_ready=0, continuous requests. Required:
  - Exactly 4 issues, then req_ready all 0.
  - After resp_ready rises, one pop frees one credit and exactly one new issue follows one cycle later.
- Push and pop in the same cycle with resp_count=2. Required: resp_count stays 2 and data order is preserved across 2×RESP_DEPTH wraps.
- Force sort_valid_out=1 with no issue outstanding. Required: err_orphan=1 next cycle, stays 1, and resp_valid stays 0.
- Assert rst=0 asynchronously mid-cycle with 3 vectors in flight. Required:
  - Outputs clear immediately, without waiting for a clock edge.
  - After release, no stale responses appear.
  - The first new grant goes to requester 0.

Source files
------------

// File: rtl/bitonic_sort_scheduler_if.sv
// Client, sorter and response signals of the shared-sorter scheduler.
// master = scheduler side, slave = environment (clients, sorter, consumer).
interface bitonic_sort_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]                       req_valid;
  logic [NREQ-1:0]                       req_ready;
  logic [NREQ-1:0][DEPTH-1:0][WIDTH-1:0] req_data;
  logic                                  sort_valid_in;
  logic [DEPTH-1:0][WIDTH-1:0]           sort_seq_in;
  logic                                  sort_valid_out;
  logic [DEPTH-1:0][WIDTH-1:0]           sort_seq_out;
  logic                                  resp_valid;
  logic                                  resp_ready;
  logic [IDW-1:0]                        resp_id;
  logic [DEPTH-1:0][WIDTH-1:0]           resp_data;
  logic                                  err_orphan;

  modport master (
    input  req_valid, req_data, sort_valid_out, sort_seq_out, resp_ready,
    output req_ready, sort_valid_in, sort_seq_in, resp_valid, resp_id, resp_data, err_orphan
  );

  modport slave (
    output req_valid, req_data, sort_valid_out, sort_seq_out, resp_ready,
    input  req_ready, sort_valid_in, sort_seq_in, resp_valid, resp_id, resp_data, err_orphan
  );
endinterface

// File: rtl/bitonic_sort_scheduler.sv
// Round-robin issue of client vectors into one non-stalling sorter; grant-to-sort_valid_in is 1 cycle.
// Issue is credit-limited so in-flight plus buffered results never exceed RESP_DEPTH; responses use valid/ready.
module bitonic_sort_scheduler #(
  parameter int NREQ       = 4,
  parameter int DEPTH      = 8,
  parameter int WIDTH      = 32,
  parameter int RESP_DEPTH = 4,
  localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input logic                       clk,
  input logic                       rst,
  bitonic_sort_scheduler_if.master  sched_if
);
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = PW + 1;

  typedef logic [DEPTH-1:0][WIDTH-1:0] vec_t;

  logic           sort_vld_q, sort_vld_d;
  vec_t           sort_seq_q, sort_seq_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           err_q, err_d;

  logic [IDW-1:0] tag_mem_q [RESP_DEPTH];
  logic [PW-1:0]  tag_wr_q, tag_rd_q;
  logic [CW-1:0]  tag_cnt_q, tag_cnt_d;

  vec_t           resp_dat_mem_q [RESP_DEPTH];
  logic [IDW-1:0] resp_id_mem_q  [RESP_DEPTH];
  logic [PW-1:0]  resp_wr_q, resp_rd_q;
  logic [CW-1:0]  resp_cnt_q, resp_cnt_d;

  logic [CW:0]     total;
  logic            credit, issue, cmpl, orphan, pop, gnt_found;
  logic [IDW-1:0]  gnt_idx, cand;
  logic [NREQ-1:0] gnt;

  // Credit counts only registered occupancy; a same-cycle pop frees a slot one cycle later.
  assign total  = {1'b0, tag_cnt_q} + {1'b0, resp_cnt_q};
  assign credit = (total < (CW+1)'(RESP_DEPTH));

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    gnt       = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDW'((int'(ptr_q) + i) % NREQ);
      if (!gnt_found && sched_if.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (rst && credit && gnt_found) gnt[gnt_idx] = 1'b1;
  end

  assign issue  = |gnt;
  assign cmpl   = sched_if.sort_valid_out && (tag_cnt_q != '0);
  assign orphan = sched_if.sort_valid_out && (tag_cnt_q == '0);
  assign pop    = (resp_cnt_q != '0) && sched_if.resp_ready;

  always_comb begin
    sort_vld_d = issue;
    sort_seq_d = sort_seq_q;
    ptr_d      = ptr_q;
    err_d      = err_q | orphan;
    tag_cnt_d  = tag_cnt_q;
    resp_cnt_d = resp_cnt_q;
    if (issue) begin
      sort_seq_d = sched_if.req_data[gnt_idx];
      ptr_d      = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
    if (issue && !cmpl) tag_cnt_d = tag_cnt_q + 1'b1;
    if (!issue && cmpl) tag_cnt_d = tag_cnt_q - 1'b1;
    if (cmpl && !pop)   resp_cnt_d = resp_cnt_q + 1'b1;
    if (!cmpl && pop)   resp_cnt_d = resp_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sort_vld_q <= 1'b0;
      sort_seq_q <= '0;
      ptr_q      <= '0;
      err_q      <= 1'b0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      tag_cnt_q  <= '0;
      resp_wr_q  <= '0;
      resp_rd_q  <= '0;
      resp_cnt_q <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        tag_mem_q[i]      <= '0;
        resp_id_mem_q[i]  <= '0;
        resp_dat_mem_q[i] <= '0;
      end
    end else begin
      sort_vld_q <= sort_vld_d;
      sort_seq_q <= sort_seq_d;
      ptr_q      <= ptr_d;
      err_q      <= err_d;
      tag_cnt_q  <= tag_cnt_d;
      resp_cnt_q <= resp_cnt_d;
      if (issue) begin
        tag_mem_q[tag_wr_q] <= gnt_idx;
        tag_wr_q            <= tag_wr_q + 1'b1;
      end
      // Sorter is in-order, so the tag head always owns the emerging result.
      if (cmpl) begin
        resp_id_mem_q[resp_wr_q]  <= tag_mem_q[tag_rd_q];
        resp_dat_mem_q[resp_wr_q] <= sched_if.sort_seq_out;
        tag_rd_q                  <= tag_rd_q + 1'b1;
        resp_wr_q                 <= resp_wr_q + 1'b1;
      end
      if (pop) resp_rd_q <= resp_rd_q + 1'b1;
    end
  end

  assign sched_if.req_ready     = gnt;
  assign sched_if.sort_valid_in = sort_vld_q;
  assign sched_if.sort_seq_in   = sort_seq_q;
  assign sched_if.resp_valid    = (resp_cnt_q != '0);
  assign sched_if.resp_id       = resp_id_mem_q[resp_rd_q];
  assign sched_if.resp_data     = resp_dat_mem_q[resp_rd_q];
  assign sched_if.err_orphan    = err_q;

  a_resp_cnt: assert property (@(posedge clk) disable iff (!rst) resp_cnt_q <= CW'(RESP_DEPTH));
  a_tag_cnt:  assert property (@(posedge clk) disable iff (!rst) tag_cnt_q  <= CW'(RESP_DEPTH));
endmodule

// File: tb/tb_bitonic_sort_scheduler.sv
// Bench for bitonic_sort_scheduler with a 6-cycle ascending-sort stub and a response scoreboard.
module tb_bitonic_sort_scheduler;
  localparam int NREQ = 4, DEPTH = 8, WIDTH = 32, RESP_DEPTH = 4, IDW = 2;
  typedef logic [DEPTH-1:0][WIDTH-1:0] vec_t;
  typedef struct { logic [IDW-1:0] rid; vec_t din; vec_t dexp; } vec_rec_t;
  typedef struct { logic [IDW-1:0] id; vec_t dat; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_orph = 1'b0;
  always #5 clk = ~clk;

  bitonic_sort_scheduler_if #(.NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  bitonic_sort_scheduler #(.NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH), .RESP_DEPTH(RESP_DEPTH)) dut (
    .clk(clk), .rst(rst), .sched_if(bus)
  );

  function automatic vec_t sort_fn(input vec_t v);
    vec_t s;
    logic [WIDTH-1:0] t;
    s = v;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH - 1 - i; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    return s;
  endfunction

  function automatic vec_t mk(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
    vec_t v;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    v[4] = a4; v[5] = a5; v[6] = a6; v[7] = a7;
    return v;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    for (int i = 0; i < DEPTH; i++) v[i] = $urandom;
    return v;
  endfunction

  // Stub sorter: fixed 6-cycle latency, index 0 holds the smallest element.
  logic [5:0] sv_pipe;
  vec_t       sd_pipe [6];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sv_pipe <= '0;
      for (int i = 0; i < 6; i++) sd_pipe[i] <= '0;
    end else begin
      sv_pipe    <= {sv_pipe[4:0], bus.sort_valid_in};
      sd_pipe[0] <= sort_fn(bus.sort_seq_in);
      for (int i = 1; i < 6; i++) sd_pipe[i] <= sd_pipe[i-1];
    end
  end
  assign bus.sort_valid_out = sv_pipe[5] | force_orph;
  assign bus.sort_seq_out   = sd_pipe[5];

  int   total = 0, bad = 0;
  int   hs_cnt = 0, beats = 0;
  exp_t exp_q [$];
  int   gnt_log [$];
  logic hold_pend = 1'b0;
  logic [IDW-1:0] hold_id;
  vec_t hold_dat;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: expected event did not happen as required", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin tick(); n++; end
    if (exp_q.size() != 0) fail(nm);
    repeat (4) tick();
  endtask

  // Monitor: samples mid-cycle, the values the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst) begin
      hold_pend = 1'b0;
    end else begin
      chk("rdy_onehot", ($countones(bus.req_ready) <= 1), 1);
      chk("rdy_implies_vld", bus.req_ready & ~bus.req_valid, 0);
      for (int r = 0; r < NREQ; r++)
        if (bus.req_valid[r] && bus.req_ready[r]) begin
          exp_q.push_back('{id: IDW'(r), dat: sort_fn(bus.req_data[r])});
          gnt_log.push_back(r);
          hs_cnt++;
        end
      if (hold_pend) begin
        chk("hold_vld", bus.resp_valid, 1);
        chk("hold_id", bus.resp_id, hold_id);
        chk("hold_dat", bus.resp_data, hold_dat);
      end
      hold_pend = bus.resp_valid && !bus.resp_ready;
      hold_id   = bus.resp_id;
      hold_dat  = bus.resp_data;
      if (bus.resp_valid && bus.resp_ready) begin
        exp_t e;
        beats++;
        if (exp_q.size() == 0) fail("resp_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("sb_id", bus.resp_id, e.id);
          chk("sb_dat", bus.resp_data, e.dat);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    vec_rec_t tbl [4];
    int n, b, b2, g0, start_g, ng, rr;
    int last [NREQ];

    tbl[0] = '{rid: 2'd2, din: mk(7, 3, 5, 1, 8, 2, 6, 4), dexp: mk(1, 2, 3, 4, 5, 6, 7, 8)};
    tbl[1] = '{rid: 2'd0, din: mk(0, 0, 0, 0, 0, 0, 0, 0), dexp: mk(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[2] = '{rid: 2'd3, din: mk(8, 7, 6, 5, 4, 3, 2, 1), dexp: mk(1, 2, 3, 4, 5, 6, 7, 8)};
    tbl[3] = '{rid: 2'd1, din: mk(32'hFFFFFFFF, 0, 5, 5, 1, 32'hFFFFFFFE, 2, 3),
               dexp: mk(0, 1, 2, 3, 5, 5, 32'hFFFFFFFE, 32'hFFFFFFFF)};

    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.resp_ready = 1'b0;
    #1 rst = 1'b0;
    #2 bus.req_valid = '1;
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_sort_vld", bus.sort_valid_in, 0);
    chk("rst_sort_seq", bus.sort_seq_in, 0);
    chk("rst_resp_vld", bus.resp_valid, 0);
    chk("rst_resp_id", bus.resp_id, 0);
    chk("rst_resp_dat", bus.resp_data, 0);
    chk("rst_err", bus.err_orphan, 0);
    tick(); tick();
    bus.req_valid = '0;
    rst = 1'b1;
    tick();

    // Single-vector table: grant same cycle, issue next edge, one response beat.
    for (int k = 0; k < 4; k++) begin
      b = beats;
      bus.req_data[tbl[k].rid] = tbl[k].din;
      bus.req_valid = 4'(1) << tbl[k].rid;
      bus.resp_ready = 1'b1;
      #1;
      chk("t_ready", bus.req_ready, 4'(1) << tbl[k].rid);
      tick();
      bus.req_valid = '0;
      chk("t_sort_vld", bus.sort_valid_in, 1);
      chk("t_sort_seq", bus.sort_seq_in, tbl[k].din);
      n = 0;
      while (!bus.resp_valid && n < 30) begin tick(); n++; end
      if (!bus.resp_valid) fail("t_resp_timeout");
      else begin
        chk("t_resp_id", bus.resp_id, tbl[k].rid);
        chk("t_resp_dat", bus.resp_data, tbl[k].dexp);
      end
      repeat (4) tick();
      chk("t_one_beat", beats - b, 1);
    end

    // Round robin with every requester asserting continuously.
    start_g = gnt_log.size();
    for (int r = 0; r < NREQ; r++) begin bus.req_data[r] = rnd_vec(); last[r] = -1; end
    bus.req_valid = '1;
    repeat (60) tick();
    bus.req_valid = '0;
    wait_drain("rr_drain");
    ng = gnt_log.size() - start_g;
    chk("rr_count", (ng >= 12), 1);
    if (ng > 0) chk("rr_first", gnt_log[start_g], (tbl[3].rid + 1) % NREQ);
    for (int i = start_g; i < gnt_log.size(); i++) begin
      rr = gnt_log[i];
      if (i > start_g) chk("rr_order", rr, (gnt_log[i-1] + 1) % NREQ);
      if (last[rr] >= 0) chk("rr_wait", ((i - last[rr]) <= NREQ), 1);
      last[rr] = i;
    end

    // Credit limit under response backpressure.
    b = hs_cnt;
    bus.resp_ready = 1'b0;
    bus.req_valid = '1;
    repeat (30) tick();
    chk("bp_issues", hs_cnt - b, RESP_DEPTH);
    chk("bp_rdy_zero", bus.req_ready, 0);
    bus.resp_ready = 1'b1;
    #1;
    chk("bp_rdy_pop_cycle", bus.req_ready, 0);
    tick();
    bus.resp_ready = 1'b0;
    #1;
    chk("bp_rdy_after_pop", (bus.req_ready != 0), 1);
    b2 = hs_cnt;
    tick();
    chk("bp_sort_vld", bus.sort_valid_in, 1);
    chk("bp_one_issue", hs_cnt - b2, 1);
    repeat (20) tick();
    chk("bp_total_issues", hs_cnt - b, RESP_DEPTH + 1);
    chk("bp_rdy_zero2", bus.req_ready, 0);
    bus.req_valid = '0;
    bus.resp_ready = 1'b1;
    wait_drain("bp_drain");

    // Hold two responses, then pop only when a result arrives: simultaneous push/pop.
    bus.resp_ready = 1'b0;
    b = hs_cnt;
    bus.req_data[1] = rnd_vec();
    bus.req_valid = 4'b0010;
    n = 0;
    while (hs_cnt - b < 2 && n < 20) begin tick(); bus.req_data[1] = rnd_vec(); n++; end
    bus.req_valid = '0;
    repeat (15) tick();
    chk("pp_pre_cnt", dut.resp_cnt_q, 2);
    chk("pp_pre_vld", bus.resp_valid, 1);
    b = beats;
    n = 0;
    while (beats - b < 8 * RESP_DEPTH + 4 && n < 800) begin
      bus.req_valid = 4'b0010;
      bus.req_data[1] = rnd_vec();
      bus.resp_ready = bus.sort_valid_out;
      @(negedge clk);
      chk("pp_cnt", dut.resp_cnt_q, 2);
      chk("pp_vld", bus.resp_valid, 1);
      tick();
      n++;
    end
    if (beats - b < 8 * RESP_DEPTH + 4) fail("pp_timeout");
    bus.req_valid = '0;
    bus.resp_ready = 1'b1;
    wait_drain("pp_drain");
    repeat (10) tick();

    // Orphan result with nothing outstanding.
    chk("orph_pre", bus.err_orphan, 0);
    b = beats;
    force_orph = 1'b1;
    tick();
    force_orph = 1'b0;
    chk("orph_set", bus.err_orphan, 1);
    repeat (5) begin
      tick();
      chk("orph_sticky", bus.err_orphan, 1);
      chk("orph_no_resp", bus.resp_valid, 0);
    end
    chk("orph_beats", beats - b, 0);

    // Asynchronous reset with three vectors in flight.
    b = hs_cnt;
    for (int r = 0; r < NREQ; r++) bus.req_data[r] = rnd_vec();
    bus.req_valid = '1;
    n = 0;
    while (hs_cnt - b < 3 && n < 20) begin tick(); n++; end
    bus.req_valid = '0;
    tick();
    chk("rst_inflight_nz", (bus.sort_seq_in != '0), 1);
    bus.req_valid = '1;
    #2 rst = 1'b0;
    #1;
    chk("arst_req_ready", bus.req_ready, 0);
    chk("arst_sort_vld", bus.sort_valid_in, 0);
    chk("arst_sort_seq", bus.sort_seq_in, 0);
    chk("arst_resp_vld", bus.resp_valid, 0);
    chk("arst_resp_id", bus.resp_id, 0);
    chk("arst_resp_dat", bus.resp_data, 0);
    chk("arst_err", bus.err_orphan, 0);
    exp_q.delete();
    repeat (3) tick();
    g0 = gnt_log.size();
    b = beats;
    rst = 1'b1;
    tick();
    bus.req_valid = '0;
    if (gnt_log.size() > g0) chk("arst_first_gnt", gnt_log[g0], 0);
    else fail("arst_no_grant");
    wait_drain("arst_drain");
    repeat (10) tick();
    chk("arst_beats", beats - b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
